// File: rtl/mem_top.sv
// Memory-access stage: runs one load/store per instruction on a req/ack data bus, aligns and
// extends load data, stalls upstream until the access completes and registers the mem2wb result.
module mem_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_top_inst_valid_i,
  input  logic        mem_top_mem_read_i,
  input  logic        mem_top_mem_write_i,
  input  logic [1:0]  mem_top_mem_size_i,
  input  logic        mem_top_mem_unsigned_i,
  input  logic        mem_top_rd_en_i,
  input  logic [4:0]  mem_top_rd_index_i,
  input  logic [63:0] mem_top_rd_data_i,
  input  logic [63:0] mem_top_rs2_data_i,
  output logic        mem_top_dmem_req_o,
  output logic        mem_top_dmem_we_o,
  output logic [63:0] mem_top_dmem_addr_o,
  output logic [63:0] mem_top_dmem_wdata_o,
  output logic [7:0]  mem_top_dmem_wstrb_o,
  input  logic        mem_top_dmem_ack_i,
  input  logic [63:0] mem_top_dmem_rdata_i,
  output logic        mem_top_stall_o,
  output logic        mem_top_misalign_o,
  output logic        mem_top_ex2mem_fwd_valid_o,
  output logic        mem_top_mem2wb_valid_o,
  output logic        mem_top_mem2wb_rd_en_o,
  output logic [4:0]  mem_top_mem2wb_rd_index_o,
  output logic [63:0] mem_top_mem2wb_rd_data_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [2:0]  lo;
  logic        is_mem;
  logic        aligned;
  logic        access;
  logic        misaligned;
  logic [7:0]  strb_c;
  logic [63:0] wdata_c;
  logic [63:0] shifted;
  logic [63:0] load_c;
  logic [63:0] load_q;

  assign lo         = mem_top_rd_data_i[2:0];
  assign is_mem     = mem_top_mem_read_i | mem_top_mem_write_i;
  assign access     = mem_top_inst_valid_i & is_mem & aligned;
  assign misaligned = mem_top_inst_valid_i & is_mem & ~aligned;

  // Held high through BUSY; drops in DONE so the pipeline advances as the result retires.
  assign mem_top_stall_o = access & (state != DONE);
  assign mem_top_ex2mem_fwd_valid_o =
    mem_top_inst_valid_i & mem_top_rd_en_i & ~mem_top_mem_read_i;

  always_comb begin
    aligned = 1'b1;
    strb_c  = 8'hFF;
    wdata_c = mem_top_rs2_data_i;
    case (mem_top_mem_size_i)
      2'd0: begin
        strb_c  = 8'h01 << lo;
        wdata_c = {8{mem_top_rs2_data_i[7:0]}};
      end
      2'd1: begin
        aligned = (lo[0] == 1'b0);
        strb_c  = 8'h03 << {lo[2:1], 1'b0};
        wdata_c = {4{mem_top_rs2_data_i[15:0]}};
      end
      2'd2: begin
        aligned = (lo[1:0] == 2'b00);
        strb_c  = 8'h0F << {lo[2], 2'b00};
        wdata_c = {2{mem_top_rs2_data_i[31:0]}};
      end
      default: begin
        aligned = (lo == 3'b000);
      end
    endcase
  end

  assign shifted = mem_top_dmem_rdata_i >> {lo, 3'b000};

  always_comb begin
    load_c = shifted;
    case (mem_top_mem_size_i)
      2'd0: load_c = mem_top_mem_unsigned_i ? {56'd0, shifted[7:0]}
                                            : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: load_c = mem_top_mem_unsigned_i ? {48'd0, shifted[15:0]}
                                            : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_c = mem_top_mem_unsigned_i ? {32'd0, shifted[31:0]}
                                            : {{32{shifted[31]}}, shifted[31:0]};
      default: load_c = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                     <= IDLE;
      mem_top_dmem_req_o        <= 1'b0;
      mem_top_dmem_we_o         <= 1'b0;
      mem_top_dmem_addr_o       <= 64'd0;
      mem_top_dmem_wdata_o      <= 64'd0;
      mem_top_dmem_wstrb_o      <= 8'd0;
      mem_top_misalign_o        <= 1'b0;
      load_q                    <= 64'd0;
      mem_top_mem2wb_valid_o    <= 1'b0;
      mem_top_mem2wb_rd_en_o    <= 1'b0;
      mem_top_mem2wb_rd_index_o <= 5'd0;
      mem_top_mem2wb_rd_data_o  <= 64'd0;
    end else begin
      mem_top_misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            state                <= BUSY;
            mem_top_dmem_req_o   <= 1'b1;
            mem_top_dmem_we_o    <= mem_top_mem_write_i;
            mem_top_dmem_addr_o  <= {mem_top_rd_data_i[63:3], 3'b000};
            mem_top_dmem_wdata_o <= wdata_c;
            mem_top_dmem_wstrb_o <= strb_c;
          end else if (misaligned) begin
            mem_top_misalign_o <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_top_dmem_ack_i) begin
            mem_top_dmem_req_o <= 1'b0;
            load_q             <= load_c;
            state              <= DONE;
          end
        end
        default: state <= IDLE;
      endcase

      // Stores and faulting accesses retire without writing rd.
      if (!mem_top_stall_o) begin
        if (mem_top_inst_valid_i) begin
          mem_top_mem2wb_valid_o    <= 1'b1;
          mem_top_mem2wb_rd_en_o    <= mem_top_rd_en_i & ~mem_top_mem_write_i & ~misaligned;
          mem_top_mem2wb_rd_index_o <= mem_top_rd_index_i;
          mem_top_mem2wb_rd_data_o  <= (mem_top_mem_read_i && state == DONE) ? load_q
                                                                             : mem_top_rd_data_i;
        end else begin
          mem_top_mem2wb_valid_o <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_top.sv
// Randomized bench for mem_top with a byte-lane reference model of the bus and load alignment.
module tb_mem_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid, mem_read, mem_write, mem_unsigned, rd_en;
  logic [1:0]  mem_size;
  logic [4:0]  rd_index;
  logic [63:0] rd_data, rs2_data;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        stall, misalign, fwd_valid;
  logic        wb_valid, wb_rd_en;
  logic [4:0]  wb_rd_index;
  logic [63:0] wb_rd_data;

  int          vectors = 0;
  int          miscompares = 0;
  logic [4:0]  last_idx = '0;
  logic [63:0] last_data = '0;

  always #5 clk = ~clk;

  mem_top dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .mem_top_inst_valid_i       (inst_valid),
    .mem_top_mem_read_i         (mem_read),
    .mem_top_mem_write_i        (mem_write),
    .mem_top_mem_size_i         (mem_size),
    .mem_top_mem_unsigned_i     (mem_unsigned),
    .mem_top_rd_en_i            (rd_en),
    .mem_top_rd_index_i         (rd_index),
    .mem_top_rd_data_i          (rd_data),
    .mem_top_rs2_data_i         (rs2_data),
    .mem_top_dmem_req_o         (dmem_req),
    .mem_top_dmem_we_o          (dmem_we),
    .mem_top_dmem_addr_o        (dmem_addr),
    .mem_top_dmem_wdata_o       (dmem_wdata),
    .mem_top_dmem_wstrb_o       (dmem_wstrb),
    .mem_top_dmem_ack_i         (dmem_ack),
    .mem_top_dmem_rdata_i       (dmem_rdata),
    .mem_top_stall_o            (stall),
    .mem_top_misalign_o         (misalign),
    .mem_top_ex2mem_fwd_valid_o (fwd_valid),
    .mem_top_mem2wb_valid_o     (wb_valid),
    .mem_top_mem2wb_rd_en_o     (wb_rd_en),
    .mem_top_mem2wb_rd_index_o  (wb_rd_index),
    .mem_top_mem2wb_rd_data_o   (wb_rd_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic bit is_aligned(input logic [63:0] a, input logic [1:0] s);
    return (int'(a[2:0]) % nbytes(s)) == 0;
  endfunction

  function automatic logic [7:0] m_strb(input logic [63:0] a, input logic [1:0] s);
    int nb  = nbytes(s);
    int off = int'(a[2:0]) & ~(nb - 1);
    int m   = ((1 << nb) - 1) << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] rs2, input logic [1:0] s);
    logic [63:0] w;
    int nb = nbytes(s);
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = rs2[(i % nb)*8 +: 8];
    return w;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rdat, input logic [63:0] a,
                                         input logic [1:0] s, input bit uns);
    int nb = nbytes(s);
    logic [63:0] sh   = rdat >> (8 * int'(a[2:0]));
    logic [63:0] mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    logic [63:0] v    = sh & mask;
    if (!uns && nb < 8 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Called and returns just after a rising edge; n is the ack delay after req is first seen.
  task automatic run_inst(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input bit ren, input logic [4:0] idx, input logic [63:0] a,
                          input logic [63:0] rs2, input int n, input logic [63:0] rdat);
    bit          mem_op = rd | wr;
    bit          acc    = mem_op && is_aligned(a, sz);
    bit          mis    = mem_op && !acc;
    bit          done   = 1'b0;
    int          cyc    = 0;
    int          stalls = 0;
    logic [63:0] exp_data = (acc && rd) ? m_load(rdat, a, sz, uns) : a;
    bit          exp_en   = ren && !wr && !mis;
    inst_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    rd_en = ren; rd_index = idx; rd_data = a; rs2_data = rs2;
    while (!done) begin
      dmem_ack   = acc && (cyc == 1 + n);
      dmem_rdata = dmem_ack ? rdat : {$urandom, $urandom};
      @(negedge clk);
      if (stall) stalls++;
      if (cyc == 0) begin
        check("fwd_valid", fwd_valid, ren && !rd);
        check("stall_arrive", stall, acc);
        check("req_arrive", dmem_req, 0);
      end else if (cyc <= 1 + n) begin
        check("req_busy", dmem_req, 1);
        check("we", dmem_we, wr);
        check("addr", dmem_addr, {a[63:3], 3'b000});
        if (wr) begin
          check("wstrb", dmem_wstrb, m_strb(a, sz));
          check("wdata", dmem_wdata, m_wdata(rs2, sz));
        end
      end else begin
        check("req_done", dmem_req, 0);
        check("stall_done", stall, 0);
      end
      if (!acc || cyc == 2 + n) done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    dmem_ack = 1'b0; inst_valid = 1'b0;
    check("wb_valid", wb_valid, 1);
    check("wb_rd_en", wb_rd_en, exp_en);
    check("wb_rd_index", wb_rd_index, idx);
    check("wb_rd_data", wb_rd_data, exp_data);
    check("misalign", misalign, mis);
    check("req_after", dmem_req, 0);
    if (acc) check("stall_cycles", stalls, n + 2);
    last_idx  = idx;
    last_data = exp_data;
  endtask

  task automatic idle_cycle();
    inst_valid = 1'b0;
    @(posedge clk); #1;
    check("gap_valid", wb_valid, 0);
    check("gap_hold_idx", wb_rd_index, last_idx);
    check("gap_hold_data", wb_rd_data, last_data);
    check("gap_misalign", misalign, 0);
  endtask

  initial begin
    rst_n = 1'b0; inst_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0;
    mem_unsigned = 1'b0; rd_en = 1'b0; rd_index = '0; rd_data = '0; rs2_data = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    check("rst_misalign", misalign, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd_en", wb_rd_en, 0);
    check("rst_wb_idx", wb_rd_index, 0);
    check("rst_wb_data", wb_rd_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_inst(0, 1, 2'd3, 0, 1, 5'd2, 64'h1000, 64'h1122334455667788, 2, 64'h0);
    run_inst(0, 1, 2'd0, 0, 0, 5'd0, 64'h1005, 64'h00000000000000AB, 1, 64'h0);
    run_inst(1, 0, 2'd0, 0, 1, 5'd7, 64'h2003, 64'h0, 0, 64'h0000000080FF0000);
    run_inst(1, 0, 2'd0, 1, 1, 5'd8, 64'h2003, 64'h0, 0, 64'h0000000080FF0000);
    run_inst(1, 0, 2'd2, 0, 1, 5'd9, 64'h3002, 64'h0, 0, 64'h0);
    run_inst(0, 0, 2'd0, 0, 1, 5'd5, 64'h42, 64'h0, 0, 64'h0);
    run_inst(1, 0, 2'd0, 0, 1, 5'd5, 64'h42, 64'h0, 1, 64'h1234567890ABCDEF);
    idle_cycle();

    for (int i = 0; i < 60; i++) begin
      int          kind = $urandom_range(0, 2);
      logic [1:0]  sz   = 2'($urandom_range(0, 3));
      logic [63:0] a    = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & 3'(~(nbytes(sz) - 1));
      run_inst(kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
               5'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 4),
               {$urandom, $urandom});
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    // Reset while the bus transaction is outstanding, then a stray ack.
    inst_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd3; mem_unsigned = 1'b0;
    rd_en = 1'b1; rd_index = 5'd11; rd_data = 64'h4000; rs2_data = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstbusy_req_before", dmem_req, 1);
    rst_n = 1'b0; inst_valid = 1'b0;
    @(posedge clk); #1;
    check("rstbusy_req", dmem_req, 0);
    check("rstbusy_wb_valid", wb_valid, 0);
    rst_n = 1'b1; dmem_ack = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("late_ack_wb_valid", wb_valid, 0);
    check("late_ack_wb_data", wb_rd_data, 0);
    @(posedge clk); #1;
    check("late_ack_req", dmem_req, 0);
    check("late_ack_wb_valid2", wb_valid, 0);
    run_inst(0, 0, 2'd0, 0, 1, 5'd3, 64'h99, 64'h0, 0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_top.md
# mem_top

Memory-access stage of the 5-stage pipeline: the producer side of the ex2mem/mem2wb forwarding paths that the execute stage consumes. It takes the registered ex2mem instruction, runs a load/store transaction on the data-memory bus with a req/ack handshake, and aligns and extends load data. It stalls the pipeline until the access completes and registers the final result into the mem2wb stage, where it can be forwarded and written back.

## Interface
Parameters: none. Widths use `DATA_BUS`/`REG_BUS` (64 b) and `REG_INDEX_BUS` (5 b) from defines.v.
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- mem_top_inst_valid_i  in  1  ex2mem register holds a valid instruction
- mem_top_mem_read_i / mem_top_mem_write_i  in  1  load / store
- mem_top_mem_size_i  in  2  0=byte 1=half 2=word 3=dword
- mem_top_mem_unsigned_i  in  1  zero-extend load (lbu/lhu/lwu)
- mem_top_rd_en_i  in  1  instruction writes rd
- mem_top_rd_index_i  in  5  rd index
- mem_top_rd_data_i  in  64  ALU result; for loads and stores, the effective address
- mem_top_rs2_data_i  in  64  store data
- mem_top_dmem_req_o  out  1  bus request
- mem_top_dmem_we_o  out  1  1 = write
- mem_top_dmem_addr_o  out  64  address with bits [2:0] forced to 0
- mem_top_dmem_wdata_o  out  64  lane-replicated store data
- mem_top_dmem_wstrb_o  out  8  byte enables
- mem_top_dmem_ack_i  in  1  transaction complete
- mem_top_dmem_rdata_i  in  64  read data, valid with ack
- mem_top_stall_o  out  1  freeze IF/ID/EX and ex2mem
- mem_top_misalign_o  out  1  one-cycle pulse on a misaligned access
- mem_top_ex2mem_fwd_valid_o  out  1  ex2mem rd data forwardable (rd_en and not a load)
- mem_top_mem2wb_valid_o / _rd_en_o  out  1  registered
- mem_top_mem2wb_rd_index_o  out  5  registered
- mem_top_mem2wb_rd_data_o  out  64  registered result

## Operation
- An access is needed when inst_valid & (mem_read|mem_write) & aligned.
- Aligned: size 0 always; size 1 needs addr[0]=0; size 2 needs addr[1:0]=0; size 3 needs addr[2:0]=0.
- FSM states:
  - IDLE to BUSY when an access is needed. On entry, register req=1, we, addr, wdata and wstrb.
  - BUSY: hold all bus outputs stable. On ack: capture rdata, drop req, go to DONE.
  - DONE: retire to mem2wb, then return to IDLE.
- wstrb:
  - byte: 8'h01<<a[2:0]
  - half: 8'h03<<{a[2:1],1'b0}
  - word: 8'h0F<<{a[2],2'b0}
  - dword: 8'hFF
- wdata: byte is rs2[7:0] replicated 8x; half is rs2[15:0] x4; word is rs2[31:0] x2; dword is rs2.
- Load result: shift rdata right by a[2:0]*8, take the low 8/16/32/64 bits, then sign- or zero-extend per mem_unsigned. A dword load is never extended.
- Misaligned access: no bus request, misalign_o pulses for one cycle, no stall. The instruction retires with rd_en forced to 0.
- Non-memory instruction: retires in 1 cycle with rd_data_i.
- Stores retire with rd_en forced to 0.
- stall_o = inst_valid & access_needed & !(state==DONE). It is combinational, so it rises in the same cycle the instruction arrives.
- mem2wb registers load the retiring instruction when not stalled. With no valid instruction, mem2wb_valid_o=0 and the other mem2wb fields hold their values.
- ex2mem_fwd_valid_o = inst_valid & rd_en_i & !mem_read_i. The execute stage must not forward a load from ex2mem; that case is a load-use stall owned by the decode stage.

## Timing
- Reset (rst_n=0 at a clk edge): state=IDLE; req, we, misalign and all mem2wb outputs=0; addr, wdata and wstrb=0.
- Reset in BUSY: req=0 on the next edge. An ack arriving while in IDLE is ignored.
- Load/store with ack returned N cycles after req:
  - cycle 0: instruction arrives, stall_o=1
  - cycle 1: req=1
  - cycle 1+N: ack, so DONE in cycle 2+N, when stall_o=0
  - mem2wb is valid in cycle 3+N
- N=0 (ack in the same cycle req is first seen) is legal, giving a minimum of 3 cycles from arrival to mem2wb.
- req stays high until the ack cycle and is low the cycle after. Two requests are never back-to-back without an intervening IDLE/DONE cycle.
- Non-memory and misaligned instructions: mem2wb updates 1 cycle after arrival.
- Inputs are held stable by the stall; the block never re-samples ex2mem inputs while in BUSY.

## Test plan
- sd x2=0x1122334455667788 to 0x1000, ack after 2 cycles -> addr 0x1000, wstrb 0xFF, wdata 0x1122334455667788, stall high for 4 cycles, mem2wb rd_en=0.
- sb rs2=0xAB to 0x1005 -> wstrb 0x20, wdata 0xABABABABABABABAB.
- lb from 0x2003, rdata 0x00000000_80FF0000, immediate ack -> mem2wb_rd_data 0xFFFFFFFFFFFFFF80; the lbu variant -> 0x80.
- lw from 0x3002 -> misalign_o pulses, req never rises, no stall, mem2wb_valid=1 with rd_en=0.
- add result 0x42, rd=5 -> ex2mem_fwd_valid=1, mem2wb rd_data 0x42 one cycle later. The same inputs as a load -> fwd_valid=0.
- rst_n low for one cycle while BUSY -> req=0 on the next cycle; a late ack causes no mem2wb write.
